// File: rtl/pixel_sequencer.sv
// pixel_sequencer
// Frame-level controller for the pixel array. For each frame requested on
// start it drives erase, then expose, then convert, then reads every pixel
// in turn and forwards the (already Gray-decoded) array data downstream on a
// valid/ready stream.
//
// Ports
//   clk            system clock
//   reset          asynchronous active-low reset
//   start          request one frame (sampled only while idle)
//   abort          synchronous abort of the frame in progress
//   exposure_time  exposure length in cycles, latched at start (0 acts as 1)
//   busy           high whenever a frame is in progress
//   frame_done     one-cycle pulse after the last pixel handshake
//   erase/expose/convert/read/pixel_select   array controls
//   data_in        array data_out
//   pix_data/pix_index/pix_last/pix_valid/pix_ready   downstream stream
module pixel_sequencer #(
    parameter int unsigned PIXEL_COUNT    = 4,
    parameter int unsigned COUNTER_WIDTH  = 8,
    parameter int unsigned ERASE_CYCLES   = 4,
    parameter int unsigned CONVERT_CYCLES = 255,
    parameter int unsigned EXP_WIDTH      = 16,
    localparam int unsigned SEL_W = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [EXP_WIDTH-1:0]     exposure_time,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     erase,
    output logic                     expose,
    output logic                     convert,
    output logic                     read,
    output logic [SEL_W-1:0]         pixel_select,
    input  logic [COUNTER_WIDTH-1:0] data_in,
    output logic [COUNTER_WIDTH-1:0] pix_data,
    output logic [SEL_W-1:0]         pix_index,
    output logic                     pix_last,
    output logic                     pix_valid,
    input  logic                     pix_ready
);

    localparam int unsigned CW_C = $clog2(CONVERT_CYCLES + 1);
    localparam int unsigned CW_E = $clog2(ERASE_CYCLES + 1);
    localparam int unsigned TW_A = (EXP_WIDTH > CW_C) ? EXP_WIDTH : CW_C;
    localparam int unsigned TW   = (TW_A > CW_E) ? TW_A : CW_E;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(PIXEL_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        EXPOSE,
        CONVERT,
        RD_SETUP,
        RD_WAIT,
        RD_HOLD,
        DONE
    } state_t;

    state_t                   state, state_n;
    logic [TW-1:0]            timer, timer_n;
    logic [EXP_WIDTH-1:0]     exp_len, exp_len_n;
    logic [SEL_W-1:0]         idx_n;
    logic [COUNTER_WIDTH-1:0] pix_data_n;
    logic [SEL_W-1:0]         pix_index_n;
    logic                     pix_last_n;
    logic                     pix_valid_n;

    // Phase timers count down to zero; each phase is loaded with length-1
    // on entry so the phase lasts exactly its programmed number of cycles.
    always_comb begin
        state_n     = state;
        timer_n     = timer;
        exp_len_n   = exp_len;
        idx_n       = pixel_select;
        pix_data_n  = pix_data;
        pix_index_n = pix_index;
        pix_last_n  = pix_last;
        pix_valid_n = pix_valid;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n   = ERASE;
                    timer_n   = TW'(ERASE_CYCLES - 1);
                    exp_len_n = (exposure_time == '0) ? EXP_WIDTH'(1) : exposure_time;
                    idx_n     = '0;
                end
            end
            ERASE: begin
                if (timer == '0) begin
                    state_n = EXPOSE;
                    timer_n = TW'(exp_len - EXP_WIDTH'(1));
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            EXPOSE: begin
                if (timer == '0) begin
                    state_n = CONVERT;
                    timer_n = TW'(CONVERT_CYCLES - 1);
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            CONVERT: begin
                if (timer == '0) begin
                    state_n = RD_SETUP;
                    idx_n   = '0;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            RD_SETUP: begin
                state_n = RD_WAIT;
            end
            RD_WAIT: begin
                state_n     = RD_HOLD;
                pix_data_n  = data_in;
                pix_index_n = pixel_select;
                pix_last_n  = (pixel_select == LAST_IDX);
                pix_valid_n = 1'b1;
            end
            RD_HOLD: begin
                if (pix_valid && pix_ready) begin
                    pix_valid_n = 1'b0;
                    pix_last_n  = 1'b0;
                    if (pixel_select == LAST_IDX) begin
                        state_n = DONE;
                    end else begin
                        state_n = RD_SETUP;
                        idx_n   = pixel_select + SEL_W'(1);
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                idx_n   = '0;
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase

        // Abort overrides every transition above; an undelivered beat is dropped.
        if (abort && (state != IDLE)) begin
            state_n     = IDLE;
            timer_n     = '0;
            idx_n       = '0;
            pix_valid_n = 1'b0;
            pix_last_n  = 1'b0;
        end
    end

    // All outputs are registered images of the next state, so every control
    // changes on the same edge as the state it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            timer        <= '0;
            exp_len      <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            erase        <= 1'b0;
            expose       <= 1'b0;
            convert      <= 1'b0;
            read         <= 1'b0;
            pixel_select <= '0;
            pix_data     <= '0;
            pix_index    <= '0;
            pix_last     <= 1'b0;
            pix_valid    <= 1'b0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            exp_len      <= exp_len_n;
            busy         <= (state_n != IDLE);
            frame_done   <= (state_n == DONE);
            erase        <= (state_n == ERASE);
            expose       <= (state_n == EXPOSE);
            convert      <= (state_n == CONVERT);
            read         <= (state_n == RD_SETUP) || (state_n == RD_WAIT);
            pixel_select <= idx_n;
            pix_data     <= pix_data_n;
            pix_index    <= pix_index_n;
            pix_last     <= pix_last_n;
            pix_valid    <= pix_valid_n;
        end
    end

endmodule

// File: tb/tb_pixel_sequencer.sv
// Self-checking bench for pixel_sequencer: a cycle-count based frame model
// checked on every falling edge, plus hand-computed literal expectations.
module tb_pixel_sequencer;

    localparam int P  = 4;
    localparam int E  = 3;
    localparam int C  = 8;
    localparam int DW = 8;
    localparam int EW = 16;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          pix_ready = 1'b1;
    logic [EW-1:0] exposure_time = '0;
    logic [DW-1:0] base = 8'd10;
    logic          busy, frame_done, erase, expose, convert, read;
    logic [SW-1:0] pixel_select, pix_index;
    logic [DW-1:0] data_in, pix_data;
    logic          pix_last, pix_valid;

    pixel_sequencer #(
        .PIXEL_COUNT(P),
        .COUNTER_WIDTH(DW),
        .ERASE_CYCLES(E),
        .CONVERT_CYCLES(C),
        .EXP_WIDTH(EW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .exposure_time(exposure_time),
        .busy(busy),
        .frame_done(frame_done),
        .erase(erase),
        .expose(expose),
        .convert(convert),
        .read(read),
        .pixel_select(pixel_select),
        .data_in(data_in),
        .pix_data(pix_data),
        .pix_index(pix_index),
        .pix_last(pix_last),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready)
    );

    // Array model: pixel n returns base+n.
    assign data_in = base + 8'(pixel_select);

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame model: k counts cycles since the start edge; the phase is a pure
    // function of k until readout, then each pixel is 2 read cycles + hold.
    bit      m_active = 0, m_rd = 0, m_done = 0, m_valid = 0, m_last = 0;
    int      m_k = 0, m_x = 0, m_pix = 0, m_sub = 0, m_sel = 0, m_index = 0;
    logic [DW-1:0] m_data = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active = 0; m_rd = 0; m_done = 0; m_valid = 0; m_last = 0;
            m_sel = 0; m_k = 0;
        end else if (m_done) begin
            m_done = 0;
            m_sel  = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1;
                m_k      = 0;
                m_x      = (exposure_time == 0) ? 1 : int'(exposure_time);
                m_sel    = 0;
            end
        end else if (abort) begin
            m_active = 0; m_rd = 0; m_valid = 0; m_last = 0; m_sel = 0;
        end else if (!m_rd) begin
            m_k++;
            if (m_k == E + m_x + C) begin
                m_rd = 1; m_sub = 0; m_pix = 0; m_sel = 0;
            end
        end else begin
            case (m_sub)
                0: m_sub = 1;
                1: begin
                    m_sub   = 2;
                    m_valid = 1;
                    m_data  = base + 8'(m_pix);
                    m_index = m_pix;
                    m_last  = (m_pix == P - 1);
                end
                default: begin
                    if (pix_ready) begin
                        m_valid = 0;
                        if (m_last) begin
                            m_last = 0; m_active = 0; m_rd = 0; m_done = 1;
                        end else begin
                            m_pix++; m_sel = m_pix; m_sub = 0;
                        end
                    end
                end
            endcase
        end
    end

    bit chk_en = 0;
    int nbeats = 0;
    logic [DW-1:0] beat_data [0:15];
    int beat_idx [0:15];
    bit beat_last [0:15];

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("busy", 32'(busy), 32'(m_active || m_done));
            cmp("erase", 32'(erase), 32'(m_active && !m_rd && m_k < E));
            cmp("expose", 32'(expose), 32'(m_active && !m_rd && m_k >= E && m_k < E + m_x));
            cmp("convert", 32'(convert), 32'(m_active && !m_rd && m_k >= E + m_x));
            cmp("read", 32'(read), 32'(m_rd && m_sub < 2));
            cmp("pixel_select", 32'(pixel_select), 32'(m_sel));
            cmp("frame_done", 32'(frame_done), 32'(m_done));
            cmp("pix_valid", 32'(pix_valid), 32'(m_valid));
            cmp("pix_last", 32'(pix_last), 32'(m_valid && m_last));
            cmp("one_control", 32'($countones({erase, expose, convert, read}) <= 1), 32'd1);
            if (m_valid) begin
                cmp("pix_data", 32'(pix_data), 32'(m_data));
                cmp("pix_index", 32'(pix_index), 32'(m_index));
            end
            if (pix_valid && pix_ready && nbeats < 16) begin
                beat_data[nbeats] = pix_data;
                beat_idx[nbeats]  = int'(pix_index);
                beat_last[nbeats] = pix_last;
                nbeats++;
            end
        end
    end

    task automatic start_frame(input int exp);
        exposure_time = EW'(exp);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    // Runs from just after the start edge until busy falls. n is the number
    // of edges after the start edge at which idle is observed.
    task automatic run_frame(input int rnd_ready, input int abort_pct,
                             output int n, output int nd, output int ne,
                             output int nx, output int nc);
        bit fin = 0;
        n = 0; nd = -1; ne = 0; nx = 0; nc = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            ne += int'(erase); nx += int'(expose); nc += int'(convert);
            if (frame_done) nd = n;
            if (!busy) begin fin = 1; break; end
            @(posedge clk); #2;
            pix_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
            abort = (abort_pct > 0) && ($urandom % 100 < abort_pct);
            n++;
        end
        abort = 1'b0;
        pix_ready = 1'b1;
        if (!fin) cmp("frame_timeout", 32'd0, 32'd1);
    endtask

    int n, nd, ne, nx, nc;
    bit seen;

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #2;
        cmp("rst_busy", 32'(busy), 32'd0);
        cmp("rst_controls", 32'({erase, expose, convert, read, frame_done}), 32'd0);
        cmp("rst_pixel_select", 32'(pixel_select), 32'd0);
        cmp("rst_pix", 32'({pix_data, pix_index, pix_last, pix_valid}), 32'd0);
        reset = 1'b1;
        chk_en = 1;
        @(negedge clk);

        // Nominal frame: exposure 5, always ready, data 10+n
        base = 8'd10;
        nbeats = 0;
        start_frame(5);
        run_frame(0, 0, n, nd, ne, nx, nc);
        cmp("erase_cycles", 32'(ne), 32'd3);
        cmp("expose_cycles", 32'(nx), 32'd5);
        cmp("convert_cycles", 32'(nc), 32'd8);
        cmp("frame_done_edge", 32'(nd), 32'd28);
        cmp("idle_edge", 32'(n), 32'd29);
        cmp("beat_count", 32'(nbeats), 32'd4);
        for (int i = 0; i < 4; i++) begin
            cmp("beat_data", 32'(beat_data[i]), 32'(10 + i));
            cmp("beat_index", 32'(beat_idx[i]), 32'(i));
            cmp("beat_last", 32'(beat_last[i]), 32'(i == 3));
        end

        // Exposure of zero acts as one cycle
        start_frame(0);
        run_frame(0, 0, n, nd, ne, nx, nc);
        cmp("expose_zero", 32'(nx), 32'd1);
        cmp("idle_edge_exp0", 32'(n), 32'(E + 1 + C + 3 * P + 1));

        // Backpressure on pixel 1 for 6 cycles
        base = 8'd10;
        start_frame(2);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pix_valid && pix_index == 2'd1) begin seen = 1; break; end
        end
        cmp("stall_reached", 32'(seen), 32'd1);
        pix_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cmp("stall_valid", 32'(pix_valid), 32'd1);
            cmp("stall_data", 32'(pix_data), 32'd11);
            cmp("stall_index", 32'(pix_index), 32'd1);
            cmp("stall_read", 32'(read), 32'd0);
            cmp("stall_sel", 32'(pixel_select), 32'd1);
            if (i < 5) @(negedge clk);
        end
        pix_ready = 1'b1;
        run_frame(0, 0, n, nd, ne, nx, nc);

        // Abort on the second convert cycle, then a clean frame
        start_frame(3);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (convert) begin seen = 1; break; end
        end
        cmp("convert_reached", 32'(seen), 32'd1);
        @(posedge clk); #2;
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        cmp("abort_busy", 32'(busy), 32'd0);
        cmp("abort_controls", 32'({erase, expose, convert, read, frame_done, pix_valid}), 32'd0);
        repeat (3) @(negedge clk);
        start_frame(4);
        run_frame(0, 0, n, nd, ne, nx, nc);
        cmp("post_abort_done", 32'(nd), 32'(E + 4 + C + 3 * P));

        // start during expose is ignored
        start_frame(6);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (expose) begin seen = 1; break; end
        end
        cmp("expose_reached", 32'(seen), 32'd1);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        run_frame(0, 0, n, nd, ne, nx, nc);

        // start and abort together in idle: start wins
        @(negedge clk);
        exposure_time = EW'(2);
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; abort = 1'b0;
        cmp("start_abort_busy", 32'(busy), 32'd1);
        cmp("start_abort_erase", 32'(erase), 32'd1);
        run_frame(0, 0, n, nd, ne, nx, nc);

        // Asynchronous reset during readout
        start_frame(1);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pix_valid) begin seen = 1; break; end
        end
        cmp("valid_reached", 32'(seen), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        cmp("async_busy", 32'(busy), 32'd0);
        cmp("async_valid", 32'(pix_valid), 32'd0);
        cmp("async_sel", 32'(pixel_select), 32'd0);
        cmp("async_pix", 32'({pix_data, pix_index}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        cmp("post_reset_idle", 32'(busy), 32'd0);

        // Randomized frames with random backpressure and occasional aborts
        for (int f = 0; f < 10; f++) begin
            base = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_frame(int'($urandom_range(0, 12)));
            run_frame(1, (f % 3 == 0) ? 4 : 0, n, nd, ne, nx, nc);
        end

        repeat (2) @(negedge clk);
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
